imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, SRAM word-address width.
REQ-002 Parameter DATA_W, default 32, SRAM data width.
REQ-003 Parameter LINE_WORDS, default 16, ICACHE refill line length in words (power of two).
REQ-004 CLK  in  1  single clock, rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 ld_req/ld_addr/ld_data  in  1/ADDR_W/DATA_W  program-load write request; ld_gnt out 1.
REQ-007 tst_req/tst_we/tst_addr/tst_data  in  1/1/ADDR_W/DATA_W  self-test access (tst_we=1 write); tst_gnt out 1.
REQ-008 tst_rvalid/tst_rdata  out  1/DATA_W  self-test read response.
REQ-009 fe_req/fe_addr  in  1/ADDR_W  single-word fetch read; fe_gnt, fe_rvalid out 1; fe_rdata out DATA_W.
REQ-010 rf_req/rf_addr  in  1/ADDR_W  cache-line refill request; rf_busy, rf_valid, rf_done out 1; rf_offset out log2(LINE_WORDS); rf_data out DATA_W.
REQ-011 mem_csb/mem_web  out  1/1  SRAM chip select and write enable, both active-low.
REQ-012 mem_addr/mem_din  out  ADDR_W/DATA_W; mem_dout in DATA_W, valid one cycle after the read edge.

Function
REQ-013 States: IDLE, BURST; at most one SRAM access issued per cycle.
REQ-014 In IDLE, priority per cycle: ld > tst > rf > fe; exactly one *_gnt high (combinational, same cycle) when any request is present, else none.
REQ-015 Granted single access drives mem_csb=0, mem_addr=requester addr, mem_web=0 only for ld or tst with tst_we=1, mem_din=requester data; otherwise mem_web=1, mem_din=0.
REQ-016 No grant: mem_csb=1, mem_web=1, mem_addr=0, mem_din=0.
REQ-017 Read owner registered at the edge; tst_rvalid or fe_rvalid high exactly one cycle after a granted read, rdata=mem_dout; writes produce no rvalid.
REQ-018 rf grant: IDLE->BURST, base = rf_addr with low log2(LINE_WORDS) bits zeroed, offset counter=0, rf_busy=1 from the grant cycle.
REQ-019 BURST issues reads base+0 .. base+LINE_WORDS-1 on consecutive cycles; the grant cycle issues offset 0.
REQ-020 rf_valid high one cycle after each burst read, rf_offset=offset issued, rf_data=mem_dout.
REQ-021 rf_done pulses with the rf_valid of offset LINE_WORDS-1; rf_busy falls the cycle after rf_done.
REQ-022 After the last burst read BURST->IDLE; arbitration resumes in the cycle carrying the last rf_valid.
REQ-023 BURST is non-preemptible; ld/tst/fe/rf requests get no grant until IDLE.
REQ-024 rf_req while rf_busy=1 is ignored; no queued second burst.
REQ-025 Requesters hold req and payload until gnt; arbiter holds no pending state.
REQ-026 Offset counter wraps only by burst completion; no address carry beyond the line base.

Reset
REQ-027 RST=1: state IDLE, counter 0, all gnt/rvalid/rf_valid/rf_done/rf_busy 0, mem_csb=1, mem_web=1, mem_addr=0, mem_din=0, response owner cleared.
REQ-028 RST asserted mid-burst aborts it immediately; no further rf_valid and no rf_done.
REQ-029 No grant is issued in a cycle in which RST is high.

Verification
REQ-030 ld_req=1 addr 0x005 data 0xDEADBEEF, tst_req=1, fe_req=1 same cycle -> only ld_gnt=1, mem_web=0, mem_addr=0x005; next cycle tst_gnt=1.
REQ-031 tst write 0x0A5 <- 0x12345678, then tst read 0x0A5 -> tst_rvalid one cycle after grant, tst_rdata=0x12345678.
REQ-032 rf_req addr 0x047 with memory preloaded word=address -> reads 0x040..0x04F, 16 rf_valid with offsets 0..15, rf_done on offset 15, rf_busy low the next cycle.
REQ-033 fe_req held during burst -> fe_gnt 0 for 16 cycles, granted in the cycle of rf_done, fe_rvalid the following cycle.
REQ-034 RST pulse at burst offset 7 -> outputs at reset values, no rf_done; new rf_req after reset restarts from offset 0.
REQ-035 rf_req and fe_req simultaneous in IDLE -> rf wins, fe_gnt=0, fe served after burst.

Source files
------------

// File: rtl/imem_arbiter.sv
// Instruction-SRAM arbiter: fixed-priority single-word accesses (ld > tst > rf > fe)
// plus non-preemptible ICACHE line-refill bursts, one SRAM access per cycle.
module imem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          ld_req,
  input  logic [ADDR_W-1:0]             ld_addr,
  input  logic [DATA_W-1:0]             ld_data,
  output logic                          ld_gnt,
  input  logic                          tst_req,
  input  logic                          tst_we,
  input  logic [ADDR_W-1:0]             tst_addr,
  input  logic [DATA_W-1:0]             tst_data,
  output logic                          tst_gnt,
  output logic                          tst_rvalid,
  output logic [DATA_W-1:0]             tst_rdata,
  input  logic                          fe_req,
  input  logic [ADDR_W-1:0]             fe_addr,
  output logic                          fe_gnt,
  output logic                          fe_rvalid,
  output logic [DATA_W-1:0]             fe_rdata,
  input  logic                          rf_req,
  input  logic [ADDR_W-1:0]             rf_addr,
  output logic                          rf_busy,
  output logic                          rf_valid,
  output logic                          rf_done,
  output logic [$clog2(LINE_WORDS)-1:0] rf_offset,
  output logic [DATA_W-1:0]             rf_data,
  output logic                          mem_csb,
  output logic                          mem_web,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_din,
  input  logic [DATA_W-1:0]             mem_dout
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS - 1);

  typedef enum logic {S_IDLE, S_BURST} state_e;

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              tst_pend_q, tst_pend_d;
  logic              fe_pend_q, fe_pend_d;
  logic              rf_pend_q, rf_pend_d;
  logic [OFF_W-1:0]  rf_off_q, rf_off_d;
  logic              rf_gnt;

  assign tst_rvalid = tst_pend_q;
  assign fe_rvalid  = fe_pend_q;
  assign rf_valid   = rf_pend_q;
  assign rf_offset  = rf_off_q;
  assign tst_rdata  = mem_dout;
  assign fe_rdata   = mem_dout;
  assign rf_data    = mem_dout;
  assign rf_done    = rf_pend_q && (rf_off_q == '1);
  // Busy spans the grant cycle through the cycle carrying the final rf_valid.
  assign rf_busy    = rf_gnt || (state_q == S_BURST) || rf_done;

  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    base_d     = base_q;
    tst_pend_d = 1'b0;
    fe_pend_d  = 1'b0;
    rf_pend_d  = 1'b0;
    rf_off_d   = rf_off_q;
    ld_gnt     = 1'b0;
    tst_gnt    = 1'b0;
    fe_gnt     = 1'b0;
    rf_gnt     = 1'b0;
    mem_csb    = 1'b1;
    mem_web    = 1'b1;
    mem_addr   = '0;
    mem_din    = '0;
    case (state_q)
      S_IDLE: begin
        if (!RST) begin
          if (ld_req) begin
            ld_gnt   = 1'b1;
            mem_csb  = 1'b0;
            mem_web  = 1'b0;
            mem_addr = ld_addr;
            mem_din  = ld_data;
          end else if (tst_req) begin
            tst_gnt    = 1'b1;
            mem_csb    = 1'b0;
            mem_web    = !tst_we;
            mem_addr   = tst_addr;
            mem_din    = tst_we ? tst_data : '0;
            tst_pend_d = !tst_we;
          end else if (rf_req && !rf_done) begin
            // A request seen while the previous burst still reports is not taken.
            rf_gnt    = 1'b1;
            mem_csb   = 1'b0;
            mem_addr  = rf_addr & ~LINE_MASK;
            base_d    = rf_addr & ~LINE_MASK;
            off_d     = OFF_W'(1);
            state_d   = S_BURST;
            rf_pend_d = 1'b1;
            rf_off_d  = '0;
          end else if (fe_req) begin
            fe_gnt    = 1'b1;
            mem_csb   = 1'b0;
            mem_addr  = fe_addr;
            fe_pend_d = 1'b1;
          end
        end
      end
      S_BURST: begin
        mem_csb   = 1'b0;
        mem_addr  = base_q | ADDR_W'(off_q);
        rf_pend_d = 1'b1;
        rf_off_d  = off_q;
        if (off_q == '1) begin
          state_d = S_IDLE;
          off_d   = '0;
        end else begin
          off_d = off_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      off_q      <= '0;
      base_q     <= '0;
      tst_pend_q <= 1'b0;
      fe_pend_q  <= 1'b0;
      rf_pend_q  <= 1'b0;
      rf_off_q   <= '0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      base_q     <= base_d;
      tst_pend_q <= tst_pend_d;
      fe_pend_q  <= fe_pend_d;
      rf_pend_q  <= rf_pend_d;
      rf_off_q   <= rf_off_d;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: a transaction-level model predicts grants,
// SRAM bus activity and read responses; a negedge monitor checks the DUT against it.
module tb_imem_arbiter;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int LINE_WORDS = 16;
  localparam int OFF_W      = $clog2(LINE_WORDS);
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int K_TST = 1, K_FE = 2, K_RF = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic              ld_req = 1'b0, tst_req = 1'b0, tst_we = 1'b0, fe_req = 1'b0, rf_req = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0, tst_addr = '0, fe_addr = '0, rf_addr = '0;
  logic [DATA_W-1:0] ld_data = '0, tst_data = '0;
  logic              ld_gnt, tst_gnt, tst_rvalid, fe_gnt, fe_rvalid;
  logic              rf_busy, rf_valid, rf_done, mem_csb, mem_web;
  logic [DATA_W-1:0] tst_rdata, fe_rdata, rf_data, mem_din, mem_dout;
  logic [OFF_W-1:0]  rf_offset;
  logic [ADDR_W-1:0] mem_addr;

  imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS)) dut (
    .CLK(CLK), .RST(RST),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_gnt(ld_gnt),
    .tst_req(tst_req), .tst_we(tst_we), .tst_addr(tst_addr), .tst_data(tst_data),
    .tst_gnt(tst_gnt), .tst_rvalid(tst_rvalid), .tst_rdata(tst_rdata),
    .fe_req(fe_req), .fe_addr(fe_addr), .fe_gnt(fe_gnt), .fe_rvalid(fe_rvalid), .fe_rdata(fe_rdata),
    .rf_req(rf_req), .rf_addr(rf_addr), .rf_busy(rf_busy), .rf_valid(rf_valid),
    .rf_done(rf_done), .rf_offset(rf_offset), .rf_data(rf_data),
    .mem_csb(mem_csb), .mem_web(mem_web), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // Synchronous SRAM: read data appears the cycle after the read edge; preloaded word = address.
  logic [DATA_W-1:0] sram [DEPTH];
  bit sram_ready = 1'b0;
  always @(posedge CLK) begin
    if (!sram_ready) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= DATA_W'(i);
      sram_ready <= 1'b1;
    end else if (!mem_csb) begin
      if (!mem_web) sram[mem_addr] <= mem_din;
      else          mem_dout <= sram[mem_addr];
    end
  end

  typedef struct {
    int                kind;
    logic [DATA_W-1:0] data;
    int                off;
    bit                done;
  } resp_t;

  resp_t             exp_q[$];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit                ref_ready = 1'b0;
  int                burst_left = 0;
  logic [ADDR_W-1:0] burst_base = '0;
  bit                m_ld_g, m_tst_g, m_fe_g, m_rf_g;
  bit                rand_en = 1'b0;
  int                total = 0;
  int                bad = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, want);
    end
  endtask

  // Reference model + monitor, evaluated mid-cycle once inputs are stable.
  always @(negedge CLK) begin
    resp_t             e;
    bit                have, done_now;
    logic [3:0]        want_v;
    logic [2:0]        want_g;
    logic              want_csb, want_web, want_busy;
    logic [ADDR_W-1:0] want_addr;
    logic [DATA_W-1:0] want_din;
    int                k;

    if (!ref_ready) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = DATA_W'(i);
      ref_ready = 1'b1;
    end
    if (RST) begin
      exp_q.delete();
      burst_left = 0;
    end

    have = exp_q.size() != 0;
    done_now = 1'b0;
    want_v = '0;
    if (have) begin
      e = exp_q.pop_front();
      want_v = {e.kind == K_TST, e.kind == K_FE, e.kind == K_RF, e.done};
      done_now = e.done;
    end
    chk("rvalid{tst,fe,rf,done}", 64'({tst_rvalid, fe_rvalid, rf_valid, rf_done}), 64'(want_v));
    if (have && e.kind == K_TST) chk("tst_rdata", 64'(tst_rdata), 64'(e.data));
    if (have && e.kind == K_FE)  chk("fe_rdata", 64'(fe_rdata), 64'(e.data));
    if (have && e.kind == K_RF) begin
      chk("rf_data", 64'(rf_data), 64'(e.data));
      chk("rf_offset", 64'(rf_offset), 64'(e.off));
    end

    m_ld_g = 0; m_tst_g = 0; m_fe_g = 0; m_rf_g = 0;
    want_g = '0; want_csb = 1'b1; want_web = 1'b1; want_addr = '0; want_din = '0;
    want_busy = done_now;
    if (!RST) begin
      if (burst_left == 0) begin
        if (ld_req) begin
          m_ld_g = 1; want_g = 3'b100; want_csb = 1'b0; want_web = 1'b0;
          want_addr = ld_addr; want_din = ld_data;
          ref_mem[ld_addr] = ld_data;
        end else if (tst_req) begin
          m_tst_g = 1; want_g = 3'b010; want_csb = 1'b0; want_addr = tst_addr;
          if (tst_we) begin
            want_web = 1'b0; want_din = tst_data;
            ref_mem[tst_addr] = tst_data;
          end else begin
            e.kind = K_TST; e.data = ref_mem[tst_addr]; e.off = 0; e.done = 0;
            exp_q.push_back(e);
          end
        end else if (rf_req && !done_now) begin
          m_rf_g = 1;
          burst_base = rf_addr - (rf_addr % LINE_WORDS);
          burst_left = LINE_WORDS;
        end else if (fe_req) begin
          m_fe_g = 1; want_g = 3'b001; want_csb = 1'b0; want_addr = fe_addr;
          e.kind = K_FE; e.data = ref_mem[fe_addr]; e.off = 0; e.done = 0;
          exp_q.push_back(e);
        end
      end
      if (burst_left > 0) begin
        k = LINE_WORDS - burst_left;
        want_csb = 1'b0; want_busy = 1'b1;
        want_addr = burst_base + ADDR_W'(k);
        e.kind = K_RF; e.data = ref_mem[want_addr]; e.off = k; e.done = (k == LINE_WORDS - 1);
        exp_q.push_back(e);
        burst_left--;
      end
    end
    chk("gnt{ld,tst,fe}", 64'({ld_gnt, tst_gnt, fe_gnt}), 64'(want_g));
    chk("mem_csb", 64'(mem_csb), 64'(want_csb));
    chk("mem_web", 64'(mem_web), 64'(want_web));
    chk("mem_addr", 64'(mem_addr), 64'(want_addr));
    chk("mem_din", 64'(mem_din), 64'(want_din));
    chk("rf_busy", 64'(rf_busy), 64'(want_busy));
  end

  // Requesters drop after their grant; in random mode idle ones re-raise with fresh payload.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (m_ld_g)  ld_req  = 1'b0;
    if (m_tst_g) tst_req = 1'b0;
    if (m_rf_g)  rf_req  = 1'b0;
    if (m_fe_g)  fe_req  = 1'b0;
    if (rand_en) begin
      if (!ld_req && $urandom_range(0, 11) == 0) begin
        ld_req = 1'b1; ld_addr = ADDR_W'($urandom); ld_data = $urandom;
      end
      if (!tst_req && $urandom_range(0, 3) == 0) begin
        tst_req = 1'b1; tst_we = 1'($urandom_range(0, 1));
        tst_addr = ADDR_W'($urandom); tst_data = $urandom;
      end
      if (!rf_req && $urandom_range(0, 24) == 0) begin
        rf_req = 1'b1; rf_addr = ADDR_W'($urandom);
      end
      if (!fe_req && $urandom_range(0, 2) == 0) begin
        fe_req = 1'b1; fe_addr = ADDR_W'($urandom);
      end
    end
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!ld_req && !tst_req && !rf_req && !fe_req && exp_q.size() == 0 && burst_left == 0) begin
        idle = 1'b1;
        break;
      end
      tick();
    end
    if (!idle) begin
      total++;
      bad++;
      $display("FAIL wait_idle at %0t: requests still pending after 300 cycles", $time);
    end
  endtask

  initial begin
    RST = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    tick();

    // Priority: ld first, then tst, then fe.
    ld_req = 1'b1; ld_addr = 10'h005; ld_data = 32'hDEADBEEF;
    tst_req = 1'b1; tst_we = 1'b0; tst_addr = 10'h005;
    fe_req = 1'b1; fe_addr = 10'h006;
    wait_idle();

    // Self-test write then read-back.
    tst_req = 1'b1; tst_we = 1'b1; tst_addr = 10'h0A5; tst_data = 32'h12345678;
    wait_idle();
    tst_req = 1'b1; tst_we = 1'b0; tst_addr = 10'h0A5;
    wait_idle();

    // Refill and fetch together: burst wins, fetch served in the rf_done cycle.
    rf_req = 1'b1; rf_addr = 10'h047;
    fe_req = 1'b1; fe_addr = 10'h0A5;
    wait_idle();

    // Reset mid-burst, then a fresh burst from offset 0.
    rf_req = 1'b1; rf_addr = 10'h047;
    repeat (8) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    rf_req = 1'b1; rf_addr = 10'h3F9;
    wait_idle();

    rand_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (RST) RST = 1'b0;
      else if ($urandom_range(0, 249) == 0) RST = 1'b1;
    end
    rand_en = 1'b0;
    RST = 1'b0;
    wait_idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
